fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised successor to the single-register fetch stage: a decoupled instruction-fetch unit with a prefetch queue of (PC, instruction) entries, a request/valid memory port and a valid/ready handoff to decode. It sits between the instruction memory (or cache) and the decode stage. It absorbs decode stalls without refetching and supports redirect (branch, jump or interrupt restore) with queue flush. It also supports instruction injection from the interrupt FSM without disturbing queued state.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `XLEN`, 32, PC and instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `imem_req` out 1 — fetch request; held until `imem_rvalid`
- `imem_addr` out XLEN — fetch address; stable while `imem_req`=1 and not yet answered
- `imem_rvalid` in 1 — response for the current request; legal the same cycle as `imem_req` or later
- `imem_rdata` in XLEN — instruction; valid with `imem_rvalid`
- `redirect_valid` in 1 — flush the queue and refetch from `redirect_pc`
- `redirect_pc` in XLEN — new fetch address
- `inj_valid` in 1 — present `inj_instr` instead of the queue head
- `inj_instr` in XLEN — injected instruction
- `out_valid` out 1 — decode handoff valid
- `out_ready` in 1 — decode accepts; low = stall
- `out_instr` out XLEN — instruction to decode
- `out_pc` out XLEN — PC of `out_instr`
- `out_inj` out 1 — current output is injected
- `current_pc` out XLEN — head-entry PC if queue non-empty, else next fetch PC; used for interrupt PC save

## Operation
- Fetch state: `S_IDLE` (no request), `S_WAIT` (request outstanding, result kept), `S_DRAIN` (request outstanding, result discarded).
- Registers: `fetch_pc` (next address), queue, `count` (width $clog2(DEPTH+1)).
- At most one outstanding request. A request may be issued only when `count` < DEPTH.
- `S_IDLE`: if `count` < DEPTH → `S_WAIT`, and `imem_req` rises next cycle with `imem_addr`=`fetch_pc`.
- `S_WAIT`, on `imem_rvalid` with no redirect:
  - push {`fetch_pc`, `imem_rdata`};
  - `fetch_pc` += 4, modulo 2^XLEN;
  - stay in `S_WAIT` with `imem_req` held high if post-update `count` < DEPTH, else → `S_IDLE`.
- Redirect handling (`redirect_valid`=1):
  - Queue is cleared and `fetch_pc` ← `redirect_pc` at the clock edge.
  - Outstanding request without `imem_rvalid` this cycle → `S_DRAIN`. The request stays high with the old address, and its response is dropped. Then → `S_WAIT` at `fetch_pc`.
  - `imem_rvalid` in the same cycle → data dropped, → `S_WAIT` at `redirect_pc`.
  - Redirect while in `S_DRAIN` updates `fetch_pc` only.
  - Redirect while in `S_IDLE` → `S_WAIT`.
- Decode output:
  - `out_valid` = (`inj_valid` | `count`≠0) & ~`redirect_valid`.
  - Pop on `out_valid` & `out_ready` & ~`inj_valid`.
- Injection (`inj_valid`=1):
  - `out_instr`=`inj_instr`, `out_inj`=1, `out_pc`=`current_pc`.
  - The queue never pops, and fetching continues.
- When `out_valid`=0, `out_instr` = NOP (32'h7800_0000) and `out_pc` = `current_pc`.
- Push and pop in the same cycle: `count` unchanged. Overflow is impossible by the credit rule. A pop on an empty queue is impossible because `out_valid`=0.

## Timing
- Reset (async assert): state `S_IDLE`, `count`=0, `fetch_pc`=RESET_PC.
- Output values during reset: `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_instr`=NOP, `out_pc`=RESET_PC, `out_inj`=0, `current_pc`=RESET_PC.
- First cycle after reset deasserts: → `S_WAIT`. `imem_req`=1 in the following cycle.
- Zero-wait memory (`imem_rvalid` same cycle as request): one instruction per cycle sustained. `out_valid` rises one cycle after the push.
- Redirect to `out_valid` of the target instruction (zero-wait memory): 2 cycles, i.e. request in cycle +1 and output in cycle +2.
- Reset mid-request: request dropped immediately (asynchronous reset). The memory side must tolerate a request being abandoned.
- `imem_req` and `imem_addr` are registered. `out_*` signals are combinational from queue head and injection inputs.

## Structure
- `fetch_pkg`:
  - `FETCH_NOP` constant;
  - `fetch_state_t` enum;
  - `fetch_entry_t` struct {pc, instr}, parametrised by XLEN via a package localparam.
- Sub-module `fetch_fifo`:
  - synchronous FIFO of `fetch_entry_t`, depth DEPTH;
  - push, pop and clear inputs, where clear wins over push;
  - count, head and full/empty outputs.
- Top level holds the FSM, `fetch_pc`, credit logic and output muxing.

## Test plan
- Reset, zero-wait memory, `out_ready`=1 → addresses 0x0, 0x4, 0x8… on consecutive cycles. `out_pc` follows one cycle behind the push, with matching `out_instr`.
- DEPTH=4, `out_ready`=0 → exactly 4 pushes (PCs 0x0–0xC), then `imem_req`=0. Raising `out_ready` drains in order and fetch resumes at 0x10.
- 3-cycle memory latency; redirect to 0x100 in the cycle after the request to 0x8 → 0x8 response dropped, next `imem_addr`=0x100, and the first `out_pc`=0x100.
- Redirect to 0x200 coincident with `imem_rvalid` → that data is not pushed, `out_valid`=0 that cycle, and the next request is 0x200.
- `inj_valid`=1 with `inj_instr`=0xDEAD_BEEF for 3 cycles with 2 entries queued → `out_inj`=1 and `out_instr`=0xDEADBEEF for those cycles, the queue is not popped, and the head entry is then presented unchanged.
- `fetch_pc`=0xFFFF_FFFC → next request 0x0 (wrap). Asserting `rst` mid-request clears `out_valid` and `imem_req` in the same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

  // Width of PC and instruction fields carried in the prefetch queue.
  localparam int FETCH_XLEN = 32;

  // Instruction presented to decode whenever nothing valid is offered.
  localparam logic [FETCH_XLEN-1:0] FETCH_NOP = 32'h7800_0000;

  // S_WAIT keeps the response, S_DRAIN throws away the response of a request
  // that was already on the bus when a redirect arrived.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of (PC, instruction) entries with synchronous clear.
// Latency: a push is visible at the head the cycle after the clock edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers and occupancy; clear overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: one outstanding memory request feeding a prefetch queue.
// Latency: zero-wait memory gives one instruction per cycle; out_valid rises the cycle after a push.
// Backpressure: out_ready low holds the head; fetching stops once the queue is full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inj_valid,
  input  logic [XLEN-1:0] inj_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_inj,
  output logic [XLEN-1:0] current_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  // A response is only kept when it answers a live request and no redirect
  // is flushing the queue in the same cycle.
  assign push      = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop       = out_valid && out_ready && !inj_valid;
  assign push_data = '{pc: fetch_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (redirect_valid),
    .count     (count),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Next fetch PC and next fetch state.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (push)           fetch_pc_nxt = fetch_pc + XLEN'(4);
    if (redirect_valid) fetch_pc_nxt = redirect_pc;
    case (state)
      S_IDLE: begin
        if (redirect_valid || !full) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // An unanswered request cannot be withdrawn, so its answer is drained.
          state_nxt = imem_rvalid ? S_WAIT : S_DRAIN;
        end else if (imem_rvalid && !pop && (count >= CW'(DEPTH - 1))) begin
          // This push takes the last free slot: no credit for another request.
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM, fetch PC and the registered memory request; the address is frozen
  // while draining so the abandoned request stays stable on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      imem_req <= (state_nxt != S_IDLE);
      if (state_nxt != S_DRAIN) imem_addr <= fetch_pc_nxt;
    end
  end

  // Decode handoff is combinational from the queue head and the injection port.
  assign current_pc = empty ? fetch_pc : head.pc;
  assign out_valid  = (inj_valid || !empty) && !redirect_valid;
  assign out_inj    = out_valid && inj_valid;
  assign out_pc     = current_pc;
  assign out_instr  = !out_valid ? FETCH_NOP :
                      inj_valid  ? inj_instr : head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Memory model answers after a programmable number of wait cycles.
// Inputs change just after the rising edge; outputs are sampled mid-cycle.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h7800_0000;
  localparam logic [31:0] OFS = 32'h1300_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_inj;
  logic [31:0] current_pc;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;

  fetch_queue #(
    .DEPTH    (4),
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inj_valid      (inj_valid),
    .inj_instr      (inj_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_inj        (out_inj),
    .current_pc     (current_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responds once the current request has waited mem_lat cycles.
  task automatic drive();
    if (imem_req && (wait_cnt >= mem_lat)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem_addr + OFS;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #2;
  endtask

  task automatic adv();
    if (imem_rvalid)   wait_cnt = 0;
    else if (imem_req) wait_cnt++;
    else               wait_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    inj_valid      = 1'b0;
    out_ready      = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    wait_cnt       = 0;
    mem_lat        = 0;
    #2;
    chk("rst_req",    imem_req,   0);
    chk("rst_addr",   imem_addr,  32'h0);
    chk("rst_ov",     out_valid,  0);
    chk("rst_instr",  out_instr,  NOP);
    chk("rst_pc",     out_pc,     32'h0);
    chk("rst_inj",    out_inj,    0);
    chk("rst_curpc",  current_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // ---- zero-wait streaming ----
    do_reset();
    out_ready = 1'b1;
    drive(); chk("t1_idle_req", imem_req, 0); adv();
    drive(); chk("t1_req0", imem_req, 1); chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_ov0", out_valid, 0); adv();
    for (int k = 1; k <= 4; k++) begin
      drive();
      chk("t1_addr",  imem_addr, 32'(k * 4));
      chk("t1_ov",    out_valid, 1);
      chk("t1_pc",    out_pc,    32'((k - 1) * 4));
      chk("t1_instr", out_instr, 32'((k - 1) * 4) + OFS);
      adv();
    end

    // ---- decode stall fills the queue, then drains in order ----
    do_reset();
    out_ready = 1'b0;
    drive(); adv();
    for (int k = 0; k < 4; k++) begin
      drive(); chk("t2_req", imem_req, 1); chk("t2_addr", imem_addr, 32'(k * 4)); adv();
    end
    drive(); chk("t2_full_req", imem_req, 0); chk("t2_full_pc", out_pc, 32'h0);
    chk("t2_full_ov", out_valid, 1); adv();
    drive(); chk("t2_full_req2", imem_req, 0); adv();
    out_ready = 1'b1;
    drive(); chk("t2_pop0_req", imem_req, 0); chk("t2_pop0_pc", out_pc, 32'h0); adv();
    drive(); chk("t2_pop1_req", imem_req, 0); chk("t2_pop1_pc", out_pc, 32'h4); adv();
    drive(); chk("t2_resume_req", imem_req, 1); chk("t2_resume_addr", imem_addr, 32'h10);
    chk("t2_pop2_pc", out_pc, 32'h8); adv();
    drive(); chk("t2_pop3_pc", out_pc, 32'hC); adv();
    drive(); chk("t2_pop4_pc", out_pc, 32'h10); chk("t2_pop4_instr", out_instr, 32'h1300_0010); adv();

    // ---- redirect while a slow request is outstanding ----
    do_reset();
    out_ready = 1'b1;
    mem_lat   = 2;
    drive(); adv();
    drive(); chk("t3_addr0", imem_addr, 32'h0); chk("t3_ov0", out_valid, 0); adv();
    drive(); adv();
    drive(); adv();
    drive(); chk("t3_addr4", imem_addr, 32'h4); chk("t3_pc0", out_pc, 32'h0); chk("t3_ov1", out_valid, 1); adv();
    drive(); adv();
    drive(); adv();
    drive(); chk("t3_addr8", imem_addr, 32'h8); chk("t3_pc4", out_pc, 32'h4); adv();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    drive(); chk("t3_redir_ov", out_valid, 0); chk("t3_redir_addr", imem_addr, 32'h8); adv();
    redirect_valid = 1'b0;
    drive(); chk("t3_drain_req", imem_req, 1); chk("t3_drain_addr", imem_addr, 32'h8);
    chk("t3_drain_ov", out_valid, 0); chk("t3_drain_curpc", current_pc, 32'h100); adv();
    drive(); chk("t3_new_addr", imem_addr, 32'h100); chk("t3_new_ov", out_valid, 0); adv();
    drive(); chk("t3_wait1_ov", out_valid, 0); adv();
    drive(); chk("t3_wait2_ov", out_valid, 0); adv();
    drive(); chk("t3_tgt_ov", out_valid, 1); chk("t3_tgt_pc", out_pc, 32'h100);
    chk("t3_tgt_instr", out_instr, 32'h1300_0100); adv();

    // ---- redirect coincident with the memory response ----
    drive(); adv();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    drive(); chk("t4_redir_addr", imem_addr, 32'h104); chk("t4_redir_ov", out_valid, 0); adv();
    redirect_valid = 1'b0;
    drive(); chk("t4_addr", imem_addr, 32'h200); chk("t4_req", imem_req, 1);
    chk("t4_ov0", out_valid, 0); chk("t4_curpc", current_pc, 32'h200); adv();
    drive(); chk("t4_ov1", out_valid, 0); adv();
    drive(); chk("t4_ov2", out_valid, 0); adv();
    drive(); chk("t4_tgt_ov", out_valid, 1); chk("t4_tgt_pc", out_pc, 32'h200); adv();

    // ---- injection over a two-entry queue ----
    do_reset();
    out_ready = 1'b0;
    drive(); adv();
    drive(); adv();
    drive(); adv();
    mem_lat   = 40;
    inj_valid = 1'b1; inj_instr = 32'hDEAD_BEEF; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive();
      chk("t5_ov",    out_valid, 1);
      chk("t5_inj",   out_inj,   1);
      chk("t5_instr", out_instr, 32'hDEAD_BEEF);
      chk("t5_pc",    out_pc,    32'h0);
      chk("t5_req",   imem_req,  1);
      chk("t5_addr",  imem_addr, 32'h8);
      adv();
    end
    inj_valid = 1'b0; out_ready = 1'b0;
    drive(); chk("t5_head_inj", out_inj, 0); chk("t5_head_instr", out_instr, 32'h1300_0000);
    chk("t5_head_pc", out_pc, 32'h0); adv();
    out_ready = 1'b1;
    drive(); chk("t5_pop0_pc", out_pc, 32'h0); adv();
    drive(); chk("t5_pop1_pc", out_pc, 32'h4); chk("t5_pop1_instr", out_instr, 32'h1300_0004); adv();

    // ---- address wrap, then reset in the middle of a request ----
    mem_lat = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive(); chk("t6_redir_ov", out_valid, 0); adv();
    redirect_valid = 1'b0;
    drive(); chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC); adv();
    out_ready = 1'b0; mem_lat = 40;
    drive(); chk("t6_wrap_addr", imem_addr, 32'h0); chk("t6_wrap_ov", out_valid, 1);
    chk("t6_wrap_pc", out_pc, 32'hFFFF_FFFC); chk("t6_wrap_instr", out_instr, 32'h12FF_FFFC); adv();
    drive(); chk("t6_pre_req", imem_req, 1); chk("t6_pre_ov", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_req",   imem_req,   0);
    chk("t6_rst_ov",    out_valid,  0);
    chk("t6_rst_addr",  imem_addr,  32'h0);
    chk("t6_rst_curpc", current_pc, 32'h0);
    chk("t6_rst_instr", out_instr,  NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
